// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states, opcodes,
// ALU operation classes and datapath mux selects.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format depends only on the opcode, so it is valid in every state.
    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/rv_alu_dec.sv
// ALU decoder: maps the FSM's operation class plus instruction fields to the
// 3-bit ALU control code.
module rv_alu_dec
    import rv_ctrl_pkg::*;
(
    input  aluop_t      aluop,
    input  logic [2:0]  funct3,
    input  logic        op5,
    input  logic        funct7b5,
    output logic [2:0]  alu_control
);

    always_comb begin
        // NOTE: every path assigns alu_control (default arms included), so no latch is inferred.
        case (aluop)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op5 separates R-type from I-type: addi never subtracts.
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rv_mc_control.sv
// Multi-cycle RV32I control unit: Moore FSM sequencing the shared datapath,
// with inline immediate decode and an ALU decoder sub-block.
module rv_mc_control
    import rv_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    output logic        pc_write,
    output logic        adr_src,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_control,
    output logic [1:0]  imm_src,
    output logic        illegal,
    output logic        halted
);

    state_t state;
    aluop_t aluop;
    logic   supported;
    logic   pc_write_s;
    logic   mem_write_s;
    logic   ir_write_s;
    logic   reg_write_s;
    logic   illegal_s;
    logic   halted_s;

    assign supported = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                       (op == OP_I)  || (op == OP_JAL) ||
                       ((op == OP_BEQ) && (funct3 == 3'b000));

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignment keeps the state update race-free against other clocked logic.
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    if ((op == OP_LW) || (op == OP_SW))         state <= S_MEMADR;
                    else if (op == OP_R)                         state <= S_EXECR;
                    else if (op == OP_I)                         state <= S_EXECI;
                    else if (op == OP_JAL)                       state <= S_JAL;
                    else if ((op == OP_BEQ) && (funct3 == 3'b000)) state <= S_BEQ;
                    else                                         state <= ILLEGAL_TRAP ? S_HALT : S_FETCH;
                end
                S_MEMADR:   state <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: state <= S_FETCH;
                S_EXECR:    state <= S_ALUWB;
                S_EXECI:    state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_JAL:      state <= S_ALUWB;
                S_BEQ:      state <= S_FETCH;
                S_HALT:     state <= S_HALT;
                default:    state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write_s  = 1'b0;
        adr_src     = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RD2;
        aluop       = ALUOP_ADD;
        illegal_s   = 1'b0;
        halted_s    = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write_s = 1'b1;
                pc_write_s = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                illegal_s = !supported;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src  = RES_DATA;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RD1;
                aluop     = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                aluop     = ALUOP_FUNCT;
            end
            S_ALUWB: reg_write_s = 1'b1;
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                pc_write_s = 1'b1;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RD1;
                aluop      = ALUOP_SUB;
                pc_write_s = zero;
            end
            S_HALT:  halted_s = 1'b1;
            default: ;
        endcase
    end

    // Strobes are gated by rst_n so an abandoned instruction can never leave a
    // write pulse on the register bank or memory while reset is asserted.
    assign pc_write  = pc_write_s  & rst_n;
    assign mem_write = mem_write_s & rst_n;
    assign ir_write  = ir_write_s  & rst_n;
    assign reg_write = reg_write_s & rst_n;
    assign illegal   = illegal_s   & rst_n;
    assign halted    = halted_s    & rst_n;

    assign imm_src = imm_sel(op);

    rv_alu_dec u_alu_dec (
        .aluop       (aluop),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

endmodule
